// File: rtl/cpu86_tb_pkg.sv
// Shared constants and helpers for the cpu86 memory stress shim.
// Request-word field positions and the back-pressure LFSR step function.
package cpu86_tb_pkg;

    localparam logic [15:0] LFSR_TAPS   = 16'hB400;  // x^16+x^14+x^13+x^11+1, Galois form
    localparam int          REQ_WIDTH   = 64;
    localparam int          RES_WIDTH   = 32;
    localparam int          REQ_WE_POS  = 63;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return cur[0] ? ((cur >> 1) ^ LFSR_TAPS) : (cur >> 1);
    endfunction

endpackage

// File: rtl/cpu86_tb_delay_line.sv
// Valid/data shift register of DEPTH stages; DEPTH=0 degenerates to a wire.
// Shifts every cycle, so back-to-back beats keep their exact spacing.
module cpu86_tb_delay_line #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    generate
        if (DEPTH == 0) begin : g_pass
            assign out_valid = in_valid;
            assign out_data  = in_data;
        end else begin : g_shift
            logic [DEPTH-1:0] valid_q;
            logic [WIDTH-1:0] data_q [DEPTH];

            always_ff @(posedge clk) begin
                if (reset) begin
                    valid_q <= '0;
                    for (int i = 0; i < DEPTH; i++) begin
                        data_q[i] <= '0;
                    end
                end else begin
                    valid_q[0] <= in_valid;
                    data_q[0]  <= in_data;
                    for (int i = 1; i < DEPTH; i++) begin
                        valid_q[i] <= valid_q[i-1];
                        data_q[i]  <= data_q[i-1];
                    end
                end
            end

            assign out_valid = valid_q[DEPTH-1];
            assign out_data  = data_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/cpu86_mem_stress_shim.sv
// Stress stage between the cpu86 memory master and the e8086 memory model:
// skid-buffered requests with LFSR back-pressure, fixed-latency read responses.
module cpu86_mem_stress_shim
    import cpu86_tb_pkg::*;
#(
    parameter int          RES_LATENCY     = 2,
    parameter int          MAX_OUTSTANDING = 4,
    parameter int          STALL_BITS      = 2,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1,
    parameter int          REQ_WE_BIT      = REQ_WE_POS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall_en,
    input  logic                 s_axis_req_tvalid,
    output logic                 s_axis_req_tready,
    input  logic [REQ_WIDTH-1:0] s_axis_req_tdata,
    output logic                 m_axis_req_tvalid,
    input  logic                 m_axis_req_tready,
    output logic [REQ_WIDTH-1:0] m_axis_req_tdata,
    input  logic                 s_axis_res_tvalid,
    input  logic [RES_WIDTH-1:0] s_axis_res_tdata,
    output logic                 m_axis_res_tvalid,
    output logic [RES_WIDTH-1:0] m_axis_res_tdata,
    output logic [3:0]           outstanding,
    output logic                 err_unexpected_res
);

    logic [15:0]          lfsr;
    logic                 stall;
    logic [REQ_WIDTH-1:0] skid_mem [2];
    logic                 rd_ptr;
    logic                 wr_ptr;
    logic [1:0]           skid_cnt;
    logic [3:0]           out_cnt;
    logic                 head_is_read;
    logic                 head_blocked;
    logic                 req_push;
    logic                 req_pop;
    logic                 fwd_read;
    logic                 res_valid_d;
    logic [RES_WIDTH-1:0] res_data_d;

    assign stall             = stall_en & (lfsr[STALL_BITS-1:0] == '0);
    assign s_axis_req_tready = !reset & !stall & (skid_cnt != 2'd2);

    // A read at the head waits for a free slot and holds back everything queued behind it.
    assign head_is_read      = !skid_mem[rd_ptr][REQ_WE_BIT];
    assign head_blocked      = head_is_read & (out_cnt == 4'(MAX_OUTSTANDING));
    assign m_axis_req_tvalid = !reset & (skid_cnt != 2'd0) & !head_blocked;
    assign m_axis_req_tdata  = reset ? '0 : skid_mem[rd_ptr];

    assign req_push = s_axis_req_tvalid & s_axis_req_tready;
    assign req_pop  = m_axis_req_tvalid & m_axis_req_tready;
    assign fwd_read = req_pop & head_is_read;

    cpu86_tb_delay_line #(
        .WIDTH (RES_WIDTH),
        .DEPTH (RES_LATENCY)
    ) u_res_delay (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (s_axis_res_tvalid),
        .in_data   (s_axis_res_tdata),
        .out_valid (res_valid_d),
        .out_data  (res_data_d)
    );

    // Gated so a zero-latency pass-through cannot leak a response while in reset.
    assign m_axis_res_tvalid = !reset & res_valid_d;
    assign m_axis_res_tdata  = reset ? '0 : res_data_d;
    assign outstanding       = out_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr               <= LFSR_SEED;
            skid_mem[0]        <= '0;
            skid_mem[1]        <= '0;
            rd_ptr             <= 1'b0;
            wr_ptr             <= 1'b0;
            skid_cnt           <= 2'd0;
            out_cnt            <= 4'd0;
            err_unexpected_res <= 1'b0;
        end else begin
            lfsr <= lfsr_next(lfsr);

            if (req_push) begin
                skid_mem[wr_ptr] <= s_axis_req_tdata;
                wr_ptr           <= !wr_ptr;
            end
            if (req_pop) begin
                rd_ptr <= !rd_ptr;
            end
            case ({req_push, req_pop})
                2'b10:   skid_cnt <= skid_cnt + 2'd1;
                2'b01:   skid_cnt <= skid_cnt - 2'd1;
                default: skid_cnt <= skid_cnt;
            endcase

            if (fwd_read && !m_axis_res_tvalid) begin
                out_cnt <= out_cnt + 4'd1;
            end else if (!fwd_read && m_axis_res_tvalid && out_cnt != 4'd0) begin
                out_cnt <= out_cnt - 4'd1;
            end

            if (s_axis_res_tvalid && out_cnt == 4'd0 && !fwd_read) begin
                err_unexpected_res <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cpu86_mem_stress_shim.sv
// Directed bench for cpu86_mem_stress_shim: handshakes, back-pressure, outstanding limit,
// skid fill/drain, unexpected-response flag and mid-transfer reset.
module tb_cpu86_mem_stress_shim;

    logic        clk;
    logic        reset;
    logic        stall_en;
    logic        s_axis_req_tvalid;
    logic        s_axis_req_tready;
    logic [63:0] s_axis_req_tdata;
    logic        m_axis_req_tvalid;
    logic        m_axis_req_tready;
    logic [63:0] m_axis_req_tdata;
    logic        s_axis_res_tvalid;
    logic [31:0] s_axis_res_tdata;
    logic        m_axis_res_tvalid;
    logic [31:0] m_axis_res_tdata;
    logic [3:0]  outstanding;
    logic        err_unexpected_res;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [15:0] SEED = 16'hACE1;

    cpu86_mem_stress_shim dut (
        .clk                (clk),
        .reset              (reset),
        .stall_en           (stall_en),
        .s_axis_req_tvalid  (s_axis_req_tvalid),
        .s_axis_req_tready  (s_axis_req_tready),
        .s_axis_req_tdata   (s_axis_req_tdata),
        .m_axis_req_tvalid  (m_axis_req_tvalid),
        .m_axis_req_tready  (m_axis_req_tready),
        .m_axis_req_tdata   (m_axis_req_tdata),
        .s_axis_res_tvalid  (s_axis_res_tvalid),
        .s_axis_res_tdata   (s_axis_res_tdata),
        .m_axis_res_tvalid  (m_axis_res_tvalid),
        .m_axis_res_tdata   (m_axis_res_tdata),
        .outstanding        (outstanding),
        .err_unexpected_res (err_unexpected_res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] model_lfsr(input logic [15:0] v);
        logic [15:0] n;
        n = {1'b0, v[15:1]};
        if (v[0]) n = n ^ 16'hB400;
        return n;
    endfunction

    function automatic logic [63:0] rd_word(input int i);
        return {32'h0, 32'hA000_0000 | 32'(i)};
    endfunction

    function automatic logic [31:0] rsp_word(input int i);
        return 32'hC000_0000 | 32'(i);
    endfunction

    task automatic zero_inputs();
        stall_en          = 1'b0;
        s_axis_req_tvalid = 1'b0;
        s_axis_req_tdata  = '0;
        m_axis_req_tready = 1'b0;
        s_axis_res_tvalid = 1'b0;
        s_axis_res_tdata  = '0;
    endtask

    // Ends on the negedge where reset has just dropped; DUT lfsr equals SEED there.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        zero_inputs();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        zero_inputs();
        stall_en          = 1'b0;
        s_axis_req_tvalid = 1'b1;
        m_axis_req_tready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if ({s_axis_req_tready, m_axis_req_tvalid, m_axis_res_tvalid, err_unexpected_res} !== 4'b0) begin
            n_bad++;
            $display("FAIL reset_flags: got %b want 0000", {s_axis_req_tready, m_axis_req_tvalid, m_axis_res_tvalid, err_unexpected_res});
        end
        n_cmp++;
        if (outstanding !== 4'd0 || m_axis_req_tdata !== 64'd0 || m_axis_res_tdata !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_data: out=%0d req=%h res=%h want zeros", outstanding, m_axis_req_tdata, m_axis_res_tdata);
        end
        zero_inputs();
        reset = 1'b0;
    endtask

    task automatic test_basic_read();
        do_reset();
        m_axis_req_tready = 1'b1;
        @(negedge clk);
        s_axis_req_tvalid = 1'b1;
        s_axis_req_tdata  = 64'h100;
        #1;
        n_cmp++;
        if (s_axis_req_tready !== 1'b1) begin n_bad++; $display("FAIL basic_tready0: got %b want 1", s_axis_req_tready); end
        @(negedge clk);
        s_axis_req_tdata = 64'h102;
        #1;
        n_cmp++;
        if (s_axis_req_tready !== 1'b1 || m_axis_req_tvalid !== 1'b1 || m_axis_req_tdata !== 64'h100) begin
            n_bad++;
            $display("FAIL basic_fwd0: tready=%b mvalid=%b data=%h want 1 1 100", s_axis_req_tready, m_axis_req_tvalid, m_axis_req_tdata);
        end
        @(negedge clk);
        s_axis_req_tvalid = 1'b0;
        s_axis_res_tvalid = 1'b1;
        s_axis_res_tdata  = 32'hDEAD;
        #1;
        n_cmp++;
        if (m_axis_req_tvalid !== 1'b1 || m_axis_req_tdata !== 64'h102) begin
            n_bad++;
            $display("FAIL basic_fwd1: mvalid=%b data=%h want 1 102", m_axis_req_tvalid, m_axis_req_tdata);
        end
        @(negedge clk);
        s_axis_res_tdata = 32'hBEEF;
        #1;
        n_cmp++;
        if (m_axis_res_tvalid !== 1'b0) begin n_bad++; $display("FAIL basic_early: res valid=%b want 0", m_axis_res_tvalid); end
        @(negedge clk);
        s_axis_res_tvalid = 1'b0;
        #1;
        n_cmp++;
        if (m_axis_res_tvalid !== 1'b1 || m_axis_res_tdata !== 32'hDEAD || outstanding !== 4'd2) begin
            n_bad++;
            $display("FAIL basic_res0: v=%b d=%h out=%0d want 1 dead 2", m_axis_res_tvalid, m_axis_res_tdata, outstanding);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (m_axis_res_tvalid !== 1'b1 || m_axis_res_tdata !== 32'hBEEF || outstanding !== 4'd1) begin
            n_bad++;
            $display("FAIL basic_res1: v=%b d=%h out=%0d want 1 beef 1", m_axis_res_tvalid, m_axis_res_tdata, outstanding);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (m_axis_res_tvalid !== 1'b0 || outstanding !== 4'd0 || err_unexpected_res !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_idle: v=%b out=%0d err=%b want 0 0 0", m_axis_res_tvalid, outstanding, err_unexpected_res);
        end
    endtask

    task automatic test_stall_stress();
        localparam int N = 1000;
        logic [15:0] lf;
        logic [31:0] mem_q [$];
        int sent, fwd, got, cyc, accept_cyc, ratio;
        int bad_stall, bad_out;
        do_reset();
        stall_en          = 1'b1;
        m_axis_req_tready = 1'b1;
        lf = SEED;
        sent = 0; fwd = 0; got = 0; cyc = 0; accept_cyc = 0;
        bad_stall = 0; bad_out = 0;
        while (got < N && cyc < 4000) begin
            @(negedge clk);
            lf = model_lfsr(lf);
            cyc++;
            s_axis_req_tvalid = (sent < N);
            s_axis_req_tdata  = rd_word(sent);
            if (mem_q.size() > 0) begin
                s_axis_res_tvalid = 1'b1;
                s_axis_res_tdata  = mem_q.pop_front();
            end else begin
                s_axis_res_tvalid = 1'b0;
            end
            #1;
            if (lf[1:0] == 2'b00 && s_axis_req_tready && bad_stall < 5) begin
                bad_stall++;
                n_cmp++; n_bad++;
                $display("FAIL stress_stall_gate: cycle %0d tready=1 want 0 (lfsr=%h)", cyc, lf);
            end
            if (outstanding > 4'd4 && bad_out < 5) begin
                bad_out++;
                n_cmp++; n_bad++;
                $display("FAIL stress_outstanding: got %0d want <=4", outstanding);
            end
            if (m_axis_req_tvalid && m_axis_req_tready) begin
                n_cmp++;
                if (m_axis_req_tdata !== rd_word(fwd)) begin
                    n_bad++;
                    $display("FAIL stress_req_order: got %h want %h", m_axis_req_tdata, rd_word(fwd));
                end
                mem_q.push_back(rsp_word(fwd));
                fwd++;
            end
            if (m_axis_res_tvalid) begin
                n_cmp++;
                if (m_axis_res_tdata !== rsp_word(got)) begin
                    n_bad++;
                    $display("FAIL stress_res_order: got %h want %h", m_axis_res_tdata, rsp_word(got));
                end
                got++;
            end
            if (s_axis_req_tvalid && s_axis_req_tready) begin
                sent++;
                if (sent == N) accept_cyc = cyc;
            end
        end
        s_axis_req_tvalid = 1'b0;
        s_axis_res_tvalid = 1'b0;
        n_cmp++;
        if (got != N || fwd != N) begin
            n_bad++;
            $display("FAIL stress_complete: fwd=%0d got=%0d want %0d", fwd, got, N);
        end
        ratio = (accept_cyc > 0) ? (N * 100) / accept_cyc : 0;
        n_cmp++;
        if (ratio < 70 || ratio > 80) begin
            n_bad++;
            $display("FAIL stress_accept_ratio: got %0d%% (%0d cycles) want 70..80%%", ratio, accept_cyc);
        end
        n_cmp++;
        if (err_unexpected_res !== 1'b0) begin n_bad++; $display("FAIL stress_err: got %b want 0", err_unexpected_res); end
    endtask

    task automatic test_outstanding_limit();
        logic [63:0] wr;
        wr = 64'h8000_0000_0000_0077;
        do_reset();
        m_axis_req_tready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            s_axis_req_tvalid = 1'b1;
            s_axis_req_tdata  = (k < 5) ? rd_word(k) : wr;
            #1;
            n_cmp++;
            if (s_axis_req_tready !== 1'b1) begin n_bad++; $display("FAIL limit_push%0d: tready=%b want 1", k, s_axis_req_tready); end
        end
        @(negedge clk);
        s_axis_req_tvalid = 1'b0;
        #1;
        n_cmp++;
        if (m_axis_req_tvalid !== 1'b0 || m_axis_req_tdata !== rd_word(4) || outstanding !== 4'd4 || s_axis_req_tready !== 1'b0) begin
            n_bad++;
            $display("FAIL limit_block: mvalid=%b data=%h out=%0d tready=%b want 0 %h 4 0",
                     m_axis_req_tvalid, m_axis_req_tdata, outstanding, s_axis_req_tready, rd_word(4));
        end
        @(negedge clk);
        s_axis_res_tvalid = 1'b1;
        s_axis_res_tdata  = 32'h1111;
        #1;
        n_cmp++;
        if (m_axis_req_tvalid !== 1'b0) begin n_bad++; $display("FAIL limit_hold: mvalid=%b want 0", m_axis_req_tvalid); end
        @(negedge clk);
        s_axis_res_tvalid = 1'b0;
        @(negedge clk);
        #1;
        n_cmp++;
        if (m_axis_res_tvalid !== 1'b1 || m_axis_res_tdata !== 32'h1111 || m_axis_req_tvalid !== 1'b0) begin
            n_bad++;
            $display("FAIL limit_res: rv=%b rd=%h mvalid=%b want 1 1111 0", m_axis_res_tvalid, m_axis_res_tdata, m_axis_req_tvalid);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (outstanding !== 4'd3 || m_axis_req_tvalid !== 1'b1 || m_axis_req_tdata !== rd_word(4)) begin
            n_bad++;
            $display("FAIL limit_release: out=%0d mvalid=%b data=%h want 3 1 %h", outstanding, m_axis_req_tvalid, m_axis_req_tdata, rd_word(4));
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (outstanding !== 4'd4 || m_axis_req_tvalid !== 1'b1 || m_axis_req_tdata !== wr) begin
            n_bad++;
            $display("FAIL limit_write: out=%0d mvalid=%b data=%h want 4 1 %h", outstanding, m_axis_req_tvalid, m_axis_req_tdata, wr);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (m_axis_req_tvalid !== 1'b0 || outstanding !== 4'd4) begin
            n_bad++;
            $display("FAIL limit_empty: mvalid=%b out=%0d want 0 4", m_axis_req_tvalid, outstanding);
        end
    endtask

    task automatic test_skid_fill();
        logic [63:0] w [4];
        int idx, outn, cyc;
        for (int k = 0; k < 4; k++) w[k] = 64'h8000_0000_0000_0040 + 64'(k);
        do_reset();
        idx = 0; outn = 0; cyc = 0;
        while (outn < 4 && cyc < 30) begin
            @(negedge clk);
            m_axis_req_tready = (cyc >= 10);
            s_axis_req_tvalid = (idx < 4);
            s_axis_req_tdata  = w[idx < 4 ? idx : 3];
            #1;
            if (cyc == 9) begin
                n_cmp++;
                if (s_axis_req_tready !== 1'b0 || m_axis_req_tvalid !== 1'b1 || m_axis_req_tdata !== w[0] || idx != 2) begin
                    n_bad++;
                    $display("FAIL skid_full: tready=%b mvalid=%b data=%h taken=%0d want 0 1 %h 2",
                             s_axis_req_tready, m_axis_req_tvalid, m_axis_req_tdata, idx, w[0]);
                end
            end
            if (m_axis_req_tvalid && m_axis_req_tready) begin
                n_cmp++;
                if (m_axis_req_tdata !== w[outn]) begin
                    n_bad++;
                    $display("FAIL skid_drain_order: got %h want %h", m_axis_req_tdata, w[outn]);
                end
                outn++;
            end
            if (s_axis_req_tvalid && s_axis_req_tready) idx++;
            cyc++;
        end
        s_axis_req_tvalid = 1'b0;
        n_cmp++;
        if (outn != 4 || idx != 4) begin
            n_bad++;
            $display("FAIL skid_drain_count: out=%0d in=%0d want 4 4", outn, idx);
        end
    endtask

    task automatic test_unexpected_res();
        do_reset();
        @(negedge clk);
        s_axis_res_tvalid = 1'b1;
        s_axis_res_tdata  = 32'h5A5A;
        #1;
        n_cmp++;
        if (err_unexpected_res !== 1'b0) begin n_bad++; $display("FAIL unexp_before: err=%b want 0", err_unexpected_res); end
        @(negedge clk);
        s_axis_res_tvalid = 1'b0;
        #1;
        n_cmp++;
        if (err_unexpected_res !== 1'b1) begin n_bad++; $display("FAIL unexp_set: err=%b want 1", err_unexpected_res); end
        @(negedge clk);
        #1;
        n_cmp++;
        if (m_axis_res_tvalid !== 1'b1 || m_axis_res_tdata !== 32'h5A5A) begin
            n_bad++;
            $display("FAIL unexp_delivered: v=%b d=%h want 1 5a5a", m_axis_res_tvalid, m_axis_res_tdata);
        end
        repeat (5) @(negedge clk);
        #1;
        n_cmp++;
        if (err_unexpected_res !== 1'b1 || outstanding !== 4'd0) begin
            n_bad++;
            $display("FAIL unexp_sticky: err=%b out=%0d want 1 0", err_unexpected_res, outstanding);
        end
    endtask

    task automatic test_mid_reset();
        logic [15:0] lf;
        stall_en          = 1'b0;
        m_axis_req_tready = 1'b0;
        @(negedge clk);
        s_axis_req_tvalid = 1'b1;
        s_axis_req_tdata  = rd_word(20);
        @(negedge clk);
        s_axis_req_tdata  = rd_word(21);
        @(negedge clk);
        s_axis_req_tvalid = 1'b0;
        s_axis_res_tvalid = 1'b1;
        s_axis_res_tdata  = 32'h2222;
        @(negedge clk);
        s_axis_res_tdata  = 32'h3333;
        @(negedge clk);
        s_axis_res_tvalid = 1'b0;
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({s_axis_req_tready, m_axis_req_tvalid, m_axis_res_tvalid} !== 3'b000) begin
            n_bad++;
            $display("FAIL rst_during: tready/mvalid/rvalid=%b want 000", {s_axis_req_tready, m_axis_req_tvalid, m_axis_res_tvalid});
        end
        @(negedge clk);
        reset    = 1'b0;
        stall_en = 1'b1;
        lf = SEED;
        #1;
        n_cmp++;
        if (m_axis_req_tvalid !== 1'b0 || m_axis_res_tvalid !== 1'b0 || outstanding !== 4'd0 || err_unexpected_res !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_after: mvalid=%b rvalid=%b out=%0d err=%b want 0 0 0 0",
                     m_axis_req_tvalid, m_axis_res_tvalid, outstanding, err_unexpected_res);
        end
        for (int k = 0; k < 10; k++) begin
            if (k > 0) begin
                @(negedge clk);
                lf = model_lfsr(lf);
                #1;
            end
            n_cmp++;
            if (s_axis_req_tready !== (lf[1:0] != 2'b00) || m_axis_res_tvalid !== 1'b0) begin
                n_bad++;
                $display("FAIL rst_lfsr_restart: step %0d tready=%b want %b rvalid=%b", k, s_axis_req_tready, (lf[1:0] != 2'b00), m_axis_res_tvalid);
            end
        end
        stall_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_read();
        test_stall_stress();
        test_outstanding_limit();
        test_skid_fill();
        test_unexpected_res();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, bench still running");
        $fatal(1, "watchdog expired");
    end

endmodule
